fp_div_seq: RTL and testbench

Multi-cycle single-precision (binary32) divider that computes q = a / b as a × (1/b), using the existing combinational fp_recip stage for 1/b.
- Sits downstream of fp_recip and feeds the FPU writeback path.
- Handles IEEE special cases itself, multiplies a by the registered reciprocal, normalises, rounds and packs the result.
- Uses valid/ready handshakes on both sides; at most one operation in flight.

---
 rtl/fp_div_seq_pkg.sv | 53 +++++
 rtl/fp_div_seq_round_pack.sv | 55 +++++
 rtl/fp_recip.sv | 38 +++
 rtl/fp_div_seq.sv | 151 +++++++++++++++
 tb/tb_fp_div_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fp_div_seq_pkg.sv
// Shared definitions for the sequential binary32 divider: format constants,
// exception flag bit positions, canonical NaN, FSM state encoding and the
// operand normalisation helper shared by fp_recip and the divider.
package fp_div_seq_pkg;

  localparam int EXP  = 8;
  localparam int FRAC = 23;
  localparam int BIAS = 127;

  // except_flags = {NV,DZ,OF,UF,NX}
  localparam int F_NV = 4;
  localparam int F_DZ = 3;
  localparam int F_OF = 2;
  localparam int F_UF = 1;
  localparam int F_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MUL    = 3'd2,
    S_PACK   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Biased exponent (may go below 1 for subnormals) and 24b mantissa with
  // the hidden bit at [23].
  typedef struct packed {
    logic signed [10:0] exp;
    logic [23:0]        man;
  } norm_t;

  // Normalise a finite nonzero magnitude; a subnormal is shifted left until
  // its leading one reaches the hidden-bit position, exponent adjusted.
  function automatic norm_t normalize(input logic [7:0] e, input logic [22:0] f);
    norm_t r;
    int    pos;
    int    shift;
    r.exp = {3'b000, e};
    r.man = {1'b1, f};
    if (e == 8'd0) begin
      pos = 0;
      for (int i = 0; i < 23; i++)
        if (f[i]) pos = i;
      shift = 23 - pos;
      r.man = 24'({1'b0, f} << shift);
      r.exp = 11'(1 - shift);
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_div_seq_round_pack.sv
// fp_round_pack: normalise the 48b mantissa product, round, detect
// overflow/underflow (flush to zero) and pack the binary32 result.
// FP_DIV_RNE_EN defined: round-to-nearest-even; undefined: truncate.
module fp_round_pack
  import fp_div_seq_pkg::*;
(
  input  logic               sign,
  input  logic signed [11:0] exp_in,
  input  logic [47:0]        prod,
  input  logic               rnx,
  output logic [31:0]        q,
  output logic [4:0]         flags
);

  logic               hi;
  logic [22:0]        frac;
  logic [23:0]        rest;
  logic signed [11:0] e;
  logic               inexact;
`ifdef FP_DIV_RNE_EN
  logic               rnd;
  logic [23:0]        sum;
`endif

  // Product is in [2^46, 2^48); bit 47 means one extra exponent step.
  always_comb begin
    hi      = prod[47];
    frac    = hi ? prod[46:24] : prod[45:23];
    rest    = hi ? prod[23:0]  : {prod[22:0], 1'b0};
    e       = exp_in + (hi ? 12'sd1 : 12'sd0);
    inexact = rnx | (rest != 24'd0);
`ifdef FP_DIV_RNE_EN
    // Truncated reciprocal means the true quotient sits above the product,
    // so its inexactness joins the sticky bit.
    rnd = rest[23] & ((|rest[22:0]) | rnx | frac[0]);
    sum = {1'b0, frac} + {23'd0, rnd};
    frac = sum[22:0];
    if (sum[23]) e = e + 12'sd1;
`endif
    flags = 5'd0;
    if (e >= 12'sd255) begin
      q = {sign, 8'hFF, 23'd0};
      flags[F_OF] = 1'b1;
      flags[F_NX] = 1'b1;
    end else if (e <= 12'sd0) begin
      q = {sign, 31'd0};
      flags[F_UF] = 1'b1;
      flags[F_NX] = 1'b1;
    end else begin
      q = {sign, e[7:0], frac};
      flags[F_NX] = inexact;
    end
  end

endmodule

// File: rtl/fp_recip.sv
// Combinational reciprocal of a binary32 magnitude: returns the biased
// exponent and 24b mantissa of 1/b, truncated, plus an inexact flag.
// Special operands (zero/inf/NaN) give don't-care values; callers classify.
module fp_recip
  import fp_div_seq_pkg::*;
(
  input  logic [30:0]        b_mag,
  output logic signed [10:0] r_exp,
  output logic [23:0]        r_man,
  output logic               r_nx
);

  localparam logic [48:0] NUM = 49'h1_0000_0000_0000;  // 2^48

  norm_t       nb;
  logic [48:0] den;
  logic [24:0] q;
  logic [23:0] rem;

  // 2^48 / m lands in (2^24, 2^25]; an exact power-of-two mantissa is its own
  // reciprocal, every other mantissa loses one exponent step.
  always_comb begin
    nb  = normalize(b_mag[30:23], b_mag[22:0]);
    den = (nb.man == 24'd0) ? 49'd1 : {25'd0, nb.man};
    q   = 25'(NUM / den);
    rem = 24'(NUM % den);
    if (nb.man == 24'h800000) begin
      r_man = 24'h800000;
      r_exp = 11'sd254 - nb.exp;
      r_nx  = 1'b0;
    end else begin
      r_man = q[24:1];
      r_exp = 11'sd253 - nb.exp;
      r_nx  = q[0] | (rem != 24'd0);
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider q = a * (1/b). One operation in flight,
// valid/ready on both sides. Normal path reaches DONE four cycles after the
// accept cycle, special operands two. Rounding selected by FP_DIV_RNE_EN.
module fp_div_seq
  import fp_div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_bits,
  input  logic [31:0] b_bits,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q_bits,
  output logic [4:0]  except_flags
);

  state_t             state;
  logic [31:0]        a_r, b_r;
  logic signed [10:0] ea_r, er_r;
  logic [23:0]        ma_r, mr_r;
  logic               rnx_r;
  logic [47:0]        prod_r;
  logic signed [11:0] exp_r;

  norm_t              na;
  logic signed [10:0] rc_exp;
  logic [23:0]        rc_man;
  logic               rc_nx;
  logic [31:0]        rp_q;
  logic [4:0]         rp_fl;

  logic               sign;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic               spec_hit;
  logic [31:0]        spec_q;
  logic [4:0]         spec_fl;

  fp_recip u_recip (
    .b_mag (b_r[30:0]),
    .r_exp (rc_exp),
    .r_man (rc_man),
    .r_nx  (rc_nx)
  );

  fp_round_pack u_pack (
    .sign   (sign),
    .exp_in (exp_r),
    .prod   (prod_r),
    .rnx    (rnx_r),
    .q      (rp_q),
    .flags  (rp_fl)
  );

  // Operand classification and the special-case result; inf/0 must be
  // caught before the DZ branch since it is an exact infinity.
  always_comb begin
    na     = normalize(a_r[30:23], a_r[22:0]);
    sign   = a_r[31] ^ b_r[31];
    a_inf  = (&a_r[30:23]) & (a_r[22:0] == 23'd0);
    b_inf  = (&b_r[30:23]) & (b_r[22:0] == 23'd0);
    a_nan  = (&a_r[30:23]) & (a_r[22:0] != 23'd0);
    b_nan  = (&b_r[30:23]) & (b_r[22:0] != 23'd0);
    a_snan = a_nan & ~a_r[22];
    b_snan = b_nan & ~b_r[22];
    a_zero = (a_r[30:0] == 31'd0);
    b_zero = (b_r[30:0] == 31'd0);
    spec_hit = 1'b1;
    spec_q   = 32'd0;
    spec_fl  = 5'd0;
    if (a_nan | b_nan) begin
      spec_q         = CANON_NAN;
      spec_fl[F_NV]  = a_snan | b_snan;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_q         = CANON_NAN;
      spec_fl[F_NV]  = 1'b1;
    end else if (a_inf) begin
      spec_q         = {sign, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_q         = {sign, 8'hFF, 23'd0};
      spec_fl[F_DZ]  = 1'b1;
    end else if (a_zero | b_inf) begin
      spec_q         = {sign, 31'd0};
    end else begin
      spec_hit       = 1'b0;
    end
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      q_bits       <= 32'd0;
      except_flags <= 5'd0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      ea_r         <= 11'sd0;
      er_r         <= 11'sd0;
      ma_r         <= 24'd0;
      mr_r         <= 24'd0;
      rnx_r        <= 1'b0;
      prod_r       <= 48'd0;
      exp_r        <= 12'sd0;
    end else begin
      case (state)
        S_IDLE: if (in_valid && in_ready) begin
          a_r      <= a_bits;
          b_r      <= b_bits;
          in_ready <= 1'b0;
          state    <= S_UNPACK;
        end
        S_UNPACK: begin
          ea_r  <= na.exp;
          ma_r  <= na.man;
          er_r  <= rc_exp;
          mr_r  <= rc_man;
          rnx_r <= rc_nx;
          if (spec_hit) begin
            q_bits       <= spec_q;
            except_flags <= spec_fl;
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end else begin
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod_r <= ma_r * mr_r;
          exp_r  <= $signed({ea_r[10], ea_r}) + $signed({er_r[10], er_r}) - 12'sd127;
          state  <= S_PACK;
        end
        S_PACK: begin
          q_bits       <= rp_q;
          except_flags <= rp_fl;
          out_valid    <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: vector table plus hold, back-to-back and
// reset-in-flight sequences.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_bits, b_bits;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q_bits;
  logic [4:0]  except_flags;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] FL_NV = 5'b10000;
  localparam logic [4:0] FL_DZ = 5'b01000;
  localparam logic [4:0] FL_OF = 5'b00100;
  localparam logic [4:0] FL_UF = 5'b00010;
  localparam logic [4:0] FL_NX = 5'b00001;

  fp_div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_bits       (a_bits),
    .b_bits       (b_bits),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .q_bits       (q_bits),
    .except_flags (except_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    int          tol;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act, input logic [31:0] exp,
                           input int tol);
    logic [31:0] d;
    checks++;
    d = (act > exp) ? act - exp : exp - act;
    if ($isunknown(act) || d > 32'(tol)) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // Present operands for one cycle and count cycles until out_valid; the
  // result is left in DONE for the caller.
  task automatic start_wait(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    a_bits   = a;
    b_bits   = b;
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic consume();
    if (out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    vecs[0]  = '{"6div2",     32'h40C00000, 32'h40000000, 32'h40400000, 1, 5'd0,          4};
    vecs[1]  = '{"n6div2",    32'hC0C00000, 32'h40000000, 32'hC0400000, 1, 5'd0,          4};
    vecs[2]  = '{"3div3",     32'h40400000, 32'h40400000, 32'h3F800000, 1, FL_NX,         4};
    vecs[3]  = '{"1div3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1, FL_NX,         4};
    vecs[4]  = '{"1p75div1p5",32'h3FE00000, 32'h3FC00000, 32'h3F955555, 1, FL_NX,         4};
    vecs[5]  = '{"subn_a",    32'h00400000, 32'h3F000000, 32'h00800000, 0, 5'd0,          4};
    vecs[6]  = '{"1div0",     32'h3F800000, 32'h00000000, 32'h7F800000, 0, FL_DZ,         2};
    vecs[7]  = '{"1divn0",    32'h3F800000, 32'h80000000, 32'hFF800000, 0, FL_DZ,         2};
    vecs[8]  = '{"0div0",     32'h00000000, 32'h00000000, 32'h7FC00000, 0, FL_NV,         2};
    vecs[9]  = '{"snan",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 0, FL_NV,         2};
    vecs[10] = '{"qnan",      32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 5'd0,          2};
    vecs[11] = '{"ninfdiv2",  32'hFF800000, 32'h40000000, 32'hFF800000, 0, 5'd0,          2};
    vecs[12] = '{"infinf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, FL_NV,         2};
    vecs[13] = '{"0div5",     32'h00000000, 32'h40A00000, 32'h00000000, 0, 5'd0,          2};
    vecs[14] = '{"2divninf",  32'h40000000, 32'hFF800000, 32'h80000000, 0, 5'd0,          2};
    vecs[15] = '{"ovf",       32'h7F000000, 32'h3E800000, 32'h7F800000, 0, FL_OF | FL_NX, 4};
    vecs[16] = '{"unf",       32'h00800000, 32'h42000000, 32'h00000000, 0, FL_UF | FL_NX, 4};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_bits = 32'd0; b_bits = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),     32'd1);
    check("rst_out_valid", 32'(out_valid),    32'd0);
    check("rst_q_bits",    q_bits,            32'd0);
    check("rst_flags",     32'(except_flags), 32'd0);

    for (int i = 0; i < 17; i++) begin
      start_wait(vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check_tol({vecs[i].name, "_q"}, q_bits, vecs[i].q, vecs[i].tol);
      check({vecs[i].name, "_flags"}, 32'(except_flags), 32'(vecs[i].fl));
      consume();
    end

    // Stall in DONE: result held, new operands refused.
    out_ready = 1'b0;
    start_wait(32'h40C00000, 32'h40000000, lat);
    check("hold_lat", 32'(lat), 32'd4);
    @(negedge clk);
    a_bits = 32'h3F800000; b_bits = 32'h40400000; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_q",        q_bits,            32'h40400000);
      check("hold_flags",    32'(except_flags), 32'd0);
      check("hold_in_ready", 32'(in_ready),     32'd0);
      check("hold_valid",    32'(out_valid),    32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready",  32'(in_ready),  32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    // in_valid is still high with 1/3, so the next edge accepts it.
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check("b2b_lat", 32'(lat), 32'd4);
    check_tol("b2b_q", q_bits, 32'h3EAAAAAB, 1);
    check("b2b_flags", 32'(except_flags), 32'(FL_NX));
    consume();

    // Reset while the multiply is in flight.
    @(negedge clk);
    a_bits = 32'h40400000; b_bits = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rstmul_out_valid", 32'(out_valid), 32'd0);
    check("rstmul_in_ready",  32'(in_ready),  32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rstmul_quiet", 32'(out_valid), 32'd0);
    end
    start_wait(32'h40400000, 32'h40400000, lat);
    check("post_rst_lat", 32'(lat), 32'd4);
    check_tol("post_rst_q", q_bits, 32'h3F800000, 1);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
